uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmit
// input port. A requester keeps the port for up to MAX_BURST accepted frames,
// or until it withdraws its send request. After each release there is one
// arbitration cycle before the next grant.
//
// Ports
//   sys_clk      system clock, rising edge
//   reset        synchronous active-high reset
//   req_si       per-requester send request
//   req_din      per-requester frames, requester i at [i*FRAME_WIDTH +: FRAME_WIDTH]
//   req_ri       per-requester ready, high on the cycle that requester's frame is taken
//   si, din      send and frame toward the UART
//   ri           ready from the UART (may depend combinationally on si)
//   grant_valid  a requester currently holds the UART
//   grant_id     index of the current or most recent holder
//
// state | meaning
// ARB   | no holder; pick the next round-robin requester, nothing transferred
// GRANT | grant_id owns the UART; frames pass while req_si[grant_id] & ri

module uart_tx_arbiter #(
    parameter int FRAME_WIDTH = 8,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic                           sys_clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_si,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]             req_ri,
    output logic                           si,
    output logic [FRAME_WIDTH-1:0]         din,
    input  logic                           ri,
    output logic                           grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_id;
    logic [ID_W-1:0] winner;
    logic            any_req;
    logic            found;
    logic [7:0]      burst_cnt;
    logic            held;
    logic            xfer;
    logic            release_now;

    // Round-robin pick: first requester at or above last_id+1, wrapping.
    always_comb begin
        winner  = last_id;
        found   = 1'b0;
        any_req = |req_si;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_si[(int'(last_id) + i) % NUM_REQ]) begin
                winner = ID_W'((int'(last_id) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    assign held = (state == GRANT) && req_si[grant_id];
    assign xfer = held && ri;

    // Burst limit counts accepted frames only, so stalls on ri never shorten a grant.
    assign release_now = (state == GRANT) &&
                         (!held || (xfer && (burst_cnt == 8'(MAX_BURST - 1))));

    // State register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (any_req)     state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Grant bookkeeping
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (any_req) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_valid <= 1'b0;
                        last_id     <= grant_id;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output logic: only the holder sees ready, and din is zero when idle.
    always_comb begin
        si     = held;
        din    = '0;
        req_ri = '0;
        if (held) begin
            din = req_din[int'(grant_id)*FRAME_WIDTH +: FRAME_WIDTH];
        end
        if (xfer) begin
            req_ri[grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester models feed frames, a cycle-level
// reference model predicts the port outputs, and a scoreboard checks that the
// frames leaving on din match each requester's submission order.

module tb_uart_tx_arbiter;

    localparam int FW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              sys_clk = 1'b0;
    logic              reset   = 1'b1;
    logic [NR-1:0]     req_si  = '0;
    logic [NR*FW-1:0]  req_din = '0;
    logic [NR-1:0]     req_ri;
    logic              si;
    logic [FW-1:0]     din;
    logic              ri = 1'b0;
    logic              grant_valid;
    logic [1:0]        grant_id;

    uart_tx_arbiter #(.FRAME_WIDTH(FW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .req_si      (req_si),
        .req_din     (req_din),
        .req_ri      (req_ri),
        .si          (si),
        .din         (din),
        .ri          (ri),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Requester side
    int          mode    = 0;   // 0 idle, 1 all, 2 only req 2, 3 random, 4 only req 1 with stalled ri
    int          pc      = 0;
    bit          rst_req = 1'b1;
    bit          has_frame [NR];
    logic [FW-1:0] cur     [NR];
    bit          accepted  [NR];
    logic [FW-1:0] exp_q   [NR][$];

    bit          log_grants = 1'b0;
    bit          prev_gv    = 1'b0;
    int          grant_log[$];

    function automatic bit active(input int i);
        return (mode == 1) || (mode == 3) || (mode == 2 && i == 2) || (mode == 4 && i == 1);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
        pc++;
        reset = rst_req || (mode == 3 && $urandom_range(0, 299) == 0);
        for (int i = 0; i < NR; i++) begin
            if (accepted[i]) begin
                has_frame[i] = 1'b0;
                accepted[i]  = 1'b0;
            end
            if (!has_frame[i] && active(i) && (mode != 3 || $urandom_range(0, 3) != 0)) begin
                cur[i]       = FW'($urandom);
                has_frame[i] = 1'b1;
                exp_q[i].push_back(cur[i]);
            end
            req_si[i] = has_frame[i] && active(i) && (mode != 3 || $urandom_range(0, 9) != 0);
            req_din[i*FW +: FW] = cur[i];
        end
        case (mode)
            1, 2:    ri = 1'b1;
            3:       ri = ($urandom_range(0, 9) < 7);
            4:       ri = (pc >= 10);
            default: ri = 1'b0;
        endcase
    endtask

    // Reference model: who holds the port and how many frames it has moved.
    bit m_known = 1'b0;
    bit m_busy  = 1'b0;
    int m_id    = 0;
    int m_last  = NR - 1;
    int m_cnt   = 0;

    always @(negedge sys_clk) begin
        logic          e_si;
        logic [FW-1:0] e_din;
        logic [NR-1:0] e_rri;
        int            win;
        if (m_known) begin
            e_si  = m_busy && req_si[m_id];
            e_din = e_si ? req_din[m_id*FW +: FW] : '0;
            e_rri = '0;
            if (e_si && ri) e_rri[m_id] = 1'b1;
            check("grant_valid", 32'(grant_valid), 32'(m_busy));
            check("grant_id",    32'(grant_id),    32'(m_id));
            check("si",          32'(si),          32'(e_si));
            check("din",         32'(din),         32'(e_din));
            check("req_ri",      32'(req_ri),      32'(e_rri));
        end
        if (log_grants && grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
        prev_gv = grant_valid;

        if (reset) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_id    = 0;
            m_last  = NR - 1;
            m_cnt   = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                win = -1;
                for (int k = 1; k <= NR; k++)
                    if (win < 0 && req_si[(m_last + k) % NR]) win = (m_last + k) % NR;
                if (win >= 0) begin
                    m_id   = win;
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else if (!req_si[m_id]) begin
                m_busy = 1'b0;
                m_last = m_id;
            end else if (ri) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_busy = 1'b0;
                    m_last = m_id;
                end
            end
        end
    end

    // Scoreboard: every frame that leaves must be the oldest one its owner submitted.
    always @(negedge sys_clk) begin
        logic [FW-1:0] exp_f;
        if (si && ri) begin
            if (exp_q[grant_id].size() == 0) begin
                check("sb_frame_available", 32'(0), 32'(1));
            end else begin
                exp_f = exp_q[grant_id].pop_front();
                check("sb_frame", 32'(din), 32'(exp_f));
            end
        end
        for (int i = 0; i < NR; i++)
            if (req_ri[i]) accepted[i] = 1'b1;
    end

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < NR; i++) begin
            has_frame[i] = 1'b0;
            accepted[i]  = 1'b0;
            cur[i]       = '0;
        end
        rst_req = 1'b1;
        mode    = 0;
        repeat (3) step();
        rst_req = 1'b0;
        repeat (2) step();

        // All four requesting: fair rotation starting at requester 0
        log_grants = 1'b1;
        mode = 1;
        repeat (30) step();
        log_grants = 1'b0;
        check("grant_log_len", 32'(grant_log.size() >= 5), 32'(1));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("grant_order_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));

        // Reset in the middle of traffic
        repeat (2) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        repeat (12) step();

        mode = 0;
        repeat (3) step();
        mode = 2;
        repeat (20) step();
        mode = 0;
        repeat (3) step();
        pc   = 0;
        mode = 4;
        repeat (25) step();
        mode = 0;
        repeat (3) step();

        mode = 3;
        repeat (2000) step();
        mode = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
